// File: rtl/ysyx_22050612_fetch_pkg.sv
// Shared definitions for the instruction-fetch responder.
package ysyx_22050612_fetch_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned INST_W = 32;
    localparam int unsigned LAT_W  = 4;

    // FSM encoding shared with anything that snoops the fetch state.
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_WAIT = 2'd1;
    localparam fetch_state_t ST_RESP = 2'd2;

    localparam logic [ADDR_W-1:0] FETCH_BASE = 64'h8000_0000;

    // addi x0, x0, 0; reserved for replacing faulting fetches with a NOP.
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    // Initial WAIT count for a given fixed latency (only used when latency > 1).
    function automatic logic [LAT_W-1:0] lat_init(input int unsigned lat);
        return LAT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/ysyx_22050612_ifetch_resp_if.sv
// Request/response handshake bundle between the IFU and the fetch responder.
interface ysyx_22050612_ifetch_resp_if;
    import ysyx_22050612_fetch_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [INST_W-1:0] resp_inst;
    logic              resp_err;

    // IFU side.
    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_inst, resp_err
    );

    // Memory/responder side.
    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_inst, resp_err
    );
endinterface

// File: rtl/ysyx_22050612_imem_array.sv
// DEPTH x 32 instruction store: asynchronous read, synchronous preload write.
// A same-cycle write and read of one word returns the old contents.
module ysyx_22050612_imem_array
    import ysyx_22050612_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     widx_i,
    input  logic [INST_W-1:0] wdata_i,
    input  logic [AW-1:0]     ridx_i,
    output logic [INST_W-1:0] rdata_o
);

    logic [INST_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[ridx_i];

    // Preload write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/ysyx_22050612_ifetch_resp.sv
// Instruction-fetch responder: accepts a pc, checks it against the instruction
// window, captures the word at accept and presents it after a fixed latency.
module ysyx_22050612_ifetch_resp
    import ysyx_22050612_fetch_pkg::*;
#(
    parameter int unsigned       DEPTH   = 4096,
    parameter logic [ADDR_W-1:0] BASE    = FETCH_BASE,
    parameter int unsigned       LATENCY = 1,
    localparam int unsigned      AW      = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_22050612_ifetch_resp_if.slave    bus,
    input  logic                          ld_en,
    input  logic [AW-1:0]                 ld_idx,
    input  logic [INST_W-1:0]             ld_data,
    output logic [63:0]                   fetch_cnt
);

    localparam logic [LAT_W-1:0] LatInit = lat_init(LATENCY);

    fetch_state_t      state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              err_q, err_d;
    logic [63:0]       fcnt_q, fcnt_d;

    logic              accept;
    logic              handshake;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] word;
    logic              addr_err;
    logic [INST_W-1:0] rdata;

    ysyx_22050612_imem_array #(
        .DEPTH (DEPTH)
    ) u_imem (
        .clk     (clk),
        .we_i    (ld_en),
        .widx_i  (ld_idx),
        .wdata_i (ld_data),
        .ridx_i  (word[AW-1:0]),
        .rdata_o (rdata)
    );

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_inst  = inst_q;
    assign bus.resp_err   = err_q;
    assign fetch_cnt      = fcnt_q;

    assign accept    = bus.req_valid && bus.req_ready;
    assign handshake = bus.resp_valid && bus.resp_ready;

    // Window check: misaligned, below BASE, or past the last word (offset wraps).
    always_comb begin
        off      = bus.req_addr - BASE;
        word     = off >> 2;
        addr_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE) ||
                   (word >= ADDR_W'(DEPTH));
    end

    // Next-state logic for the fetch FSM, latency counter and response data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        err_d   = err_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Captured here so later preloads cannot disturb this response.
                    inst_d = addr_err ? '0 : rdata;
                    err_d  = addr_err;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LatInit;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                if (handshake) begin
                    state_d = ST_IDLE;
                    fcnt_d  = fcnt_q + 64'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; pending fetch is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            inst_q  <= '0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050612_ifetch_resp.sv
// Directed bench: one responder at LATENCY=1 and one at LATENCY=4, sharing preload.
module tb_ysyx_22050612_ifetch_resp;

    logic        clk;
    logic        rst1;
    logic        rst4;
    logic        ld_en;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;
    logic [63:0] fetch_cnt1;
    logic [63:0] fetch_cnt4;

    int unsigned n_checks;
    int unsigned n_errors;

    ysyx_22050612_ifetch_resp_if if1 ();
    ysyx_22050612_ifetch_resp_if if4 ();

    ysyx_22050612_ifetch_resp #(
        .DEPTH   (4096),
        .BASE    (64'h8000_0000),
        .LATENCY (1)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst1),
        .bus       (if1.slave),
        .ld_en     (ld_en),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data),
        .fetch_cnt (fetch_cnt1)
    );

    ysyx_22050612_ifetch_resp #(
        .DEPTH   (4096),
        .BASE    (64'h8000_0000),
        .LATENCY (4)
    ) u_dut4 (
        .clk       (clk),
        .rst       (rst4),
        .bus       (if4.slave),
        .ld_en     (ld_en),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data),
        .fetch_cnt (fetch_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; write lands on the next posedge.
    task automatic preload(input logic [11:0] idx, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_idx  = idx;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Single LATENCY=1 fetch with immediate consumer, starting at a negedge in IDLE.
    task automatic fetch1(input string tag, input logic [63:0] addr,
                          input logic [31:0] exp_inst, input logic exp_err);
        check({tag, "_req_ready"}, 64'(if1.req_ready), 64'd1);
        if1.req_valid = 1'b1;
        if1.req_addr  = addr;
        @(negedge clk);
        if1.req_valid = 1'b0;
        check({tag, "_valid"}, 64'(if1.resp_valid), 64'd1);
        check({tag, "_inst"}, 64'(if1.resp_inst), 64'(exp_inst));
        check({tag, "_err"}, 64'(if1.resp_err), 64'(exp_err));
        check({tag, "_busy"}, 64'(if1.req_ready), 64'd0);
        if1.resp_ready = 1'b1;
        @(negedge clk);
        if1.resp_ready = 1'b0;
        check({tag, "_done"}, 64'(if1.resp_valid), 64'd0);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst1           = 1'b0;
        rst4           = 1'b0;
        ld_en          = 1'b0;
        ld_idx         = '0;
        ld_data        = '0;
        if1.req_valid  = 1'b0;
        if1.req_addr   = '0;
        if1.resp_ready = 1'b0;
        if4.req_valid  = 1'b0;
        if4.req_addr   = '0;
        if4.resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", 64'(if1.req_ready), 64'd1);
        check("rst_valid", 64'(if1.resp_valid), 64'd0);
        check("rst_inst", 64'(if1.resp_inst), 64'd0);
        check("rst_err", 64'(if1.resp_err), 64'd0);
        check("rst_cnt", fetch_cnt1, 64'd0);
        check("rst4_valid", 64'(if4.resp_valid), 64'd0);
        rst1 = 1'b1;
        rst4 = 1'b1;

        // Basic fetch of word 0.
        preload(12'd0, 32'h0000_0413);
        fetch1("basic", 64'h8000_0000, 32'h0000_0413, 1'b0);
        check("basic_cnt", fetch_cnt1, 64'd1);

        // Address window edges.
        preload(12'd4095, 32'h1234_5678);
        fetch1("misalign", 64'h8000_0002, 32'h0, 1'b1);
        fetch1("below", 64'h7FFF_FFFC, 32'h0, 1'b1);
        fetch1("past_end", 64'h8000_4000, 32'h0, 1'b1);
        fetch1("last_word", 64'h8000_3FFC, 32'h1234_5678, 1'b0);
        check("err_cnt", fetch_cnt1, 64'd5);

        // Same-cycle preload and accept of one word returns the old word.
        preload(12'd5, 32'hAAAA_AAAA);
        ld_en         = 1'b1;
        ld_idx        = 12'd5;
        ld_data       = 32'hBBBB_BBBB;
        if1.req_valid = 1'b1;
        if1.req_addr  = 64'h8000_0014;
        @(negedge clk);
        ld_en         = 1'b0;
        if1.req_valid = 1'b0;
        check("rbw_old", 64'(if1.resp_inst), 64'h0000_0000_AAAA_AAAA);
        if1.resp_ready = 1'b1;
        @(negedge clk);
        if1.resp_ready = 1'b0;
        fetch1("rbw_new", 64'h8000_0014, 32'hBBBB_BBBB, 1'b0);
        check("rbw_cnt", fetch_cnt1, 64'd7);

        // Back-to-back stream: one response every two cycles.
        for (int i = 0; i < 10; i++) begin
            preload(12'(i), 32'hC000_0000 + 32'(i));
        end
        if1.req_valid  = 1'b1;
        if1.resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("b2b_ready%0d", i), 64'(if1.req_ready), 64'd1);
            check($sformatf("b2b_idle%0d", i), 64'(if1.resp_valid), 64'd0);
            if1.req_addr = 64'h8000_0000 + 64'(4 * i);
            @(negedge clk);
            check($sformatf("b2b_valid%0d", i), 64'(if1.resp_valid), 64'd1);
            check($sformatf("b2b_inst%0d", i), 64'(if1.resp_inst), 64'hC000_0000 + 64'(i));
            @(negedge clk);
        end
        if1.req_valid  = 1'b0;
        if1.resp_ready = 1'b0;
        check("b2b_cnt", fetch_cnt1, 64'd17);

        // LATENCY=4 with a stalled consumer and a preload during WAIT.
        preload(12'd7, 32'hDEAD_BEEF);
        check("lat4_ready", 64'(if4.req_ready), 64'd1);
        if4.req_valid = 1'b1;
        if4.req_addr  = 64'h8000_001C;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if4.req_valid = 1'b0;
            ld_en = 1'b0;
            if (c == 2) begin
                ld_en   = 1'b1;
                ld_idx  = 12'd7;
                ld_data = 32'h0;
            end
            check($sformatf("lat4_valid%0d", c), 64'(if4.resp_valid), 64'(c >= 4));
            check($sformatf("lat4_busy%0d", c), 64'(if4.req_ready), 64'd0);
            if (c >= 4) begin
                check($sformatf("lat4_inst%0d", c), 64'(if4.resp_inst), 64'hDEAD_BEEF);
                check($sformatf("lat4_err%0d", c), 64'(if4.resp_err), 64'd0);
            end
        end
        ld_en = 1'b0;
        check("lat4_cnt_pre", fetch_cnt4, 64'd0);
        if4.resp_ready = 1'b1;
        @(negedge clk);
        if4.resp_ready = 1'b0;
        check("lat4_done", 64'(if4.resp_valid), 64'd0);
        check("lat4_cnt", fetch_cnt4, 64'd1);
        check("lat4_idle", 64'(if4.req_ready), 64'd1);

        // Reset while in WAIT discards the fetch.
        if4.req_valid = 1'b1;
        if4.req_addr  = 64'h8000_0000;
        @(negedge clk);
        if4.req_valid = 1'b0;
        check("wrst_wait", 64'(if4.req_ready), 64'd0);
        rst4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        check("wrst_ready", 64'(if4.req_ready), 64'd1);
        if4.resp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check($sformatf("wrst_novalid%0d", c), 64'(if4.resp_valid), 64'd0);
            @(negedge clk);
        end
        if4.resp_ready = 1'b0;
        check("wrst_cnt", fetch_cnt4, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
